// File: rtl/mcse_gpio_pkg.sv
// Shared definitions for the MCSE GPIO-style register packet target: packet field
// layout, datamode codes, response FSM states and the error read-data pattern.
package mcse_gpio_pkg;

    localparam int WRITE_POS = 0;
    localparam int DM_LSB    = 1;
    localparam int DM_W      = 2;
    localparam int CM_LSB    = 3;
    localparam int CM_W      = 5;
    localparam int DST_LSB   = 8;
    localparam int DATA_W    = 32;

    function automatic int data_lsb(input int aw);
        return 8 + aw;
    endfunction

    function automatic int src_lsb(input int aw);
        return 40 + aw;
    endfunction

    function automatic int pkt_width(input int aw);
        return 2 * aw + 40;
    endfunction

    localparam logic [1:0] DM_BYTE = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_WORD = 2'b10;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_BUSY = 1'b1
    } rsp_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mcse_gpio_pkt_decode.sv
// Combinational request decoder: splits a packet into fields, maps the address onto
// a register index and flags format errors (misalignment or non-word datamode).
module mcse_gpio_pkt_decode
    import mcse_gpio_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          PW        = pkt_width(AW),
    parameter int          NREG      = 8,
    parameter int          IW        = $clog2(NREG),
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic [PW-1:0]   packet,
    output logic            write,
    output logic [IW-1:0]   index,
    output logic            in_range,
    output logic            err,
    output logic [AW-1:0]   srcaddr,
    output logic [AW-1:0]   dstaddr,
    output logic [31:0]     wdata,
    output logic [CM_W-1:0] ctrlmode
);

    localparam int          DATA_LSB = data_lsb(AW);
    localparam int          SRC_LSB  = src_lsb(AW);
    localparam logic [AW:0] BASE_EXT = (AW+1)'(BASE_ADDR);
    localparam logic [AW:0] WIN_SIZE = (AW+1)'(4 * NREG);

    logic [AW:0]      offset_s;
    logic [DM_W-1:0]  datamode_s;

    // Field extraction and window decode; an address below the base wraps to a huge
    // offset, so a single unsigned compare covers both window bounds.
    always_comb begin
        write      = packet[WRITE_POS];
        datamode_s = packet[DM_LSB +: DM_W];
        ctrlmode   = packet[CM_LSB +: CM_W];
        dstaddr    = packet[DST_LSB +: AW];
        wdata      = packet[DATA_LSB +: DATA_W];
        srcaddr    = packet[SRC_LSB +: AW];
        offset_s   = {1'b0, dstaddr} - BASE_EXT;
        in_range   = (offset_s < WIN_SIZE);
        index      = offset_s[IW+1:2];
        err        = (dstaddr[1:0] != 2'b00) || (datamode_s != DM_WORD);
    end

endmodule

// File: rtl/mcse_gpio_reg_responder.sv
// Packet-addressed register bank target: word writes/reads on NREG registers, a
// registered read-response channel with wait backpressure, and sticky error stats.
module mcse_gpio_reg_responder
    import mcse_gpio_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          PW        = pkt_width(AW),
    parameter int          NREG      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter logic [31:0] BLOCK_ID  = 32'h4D43_5345
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_access,
    input  logic [PW-1:0]      reg_packet,
    output logic               reg_wait,
    output logic               rsp_access,
    output logic [PW-1:0]      rsp_packet,
    input  logic               rsp_wait,
    output logic [NREG*32-1:0] regs_out,
    output logic               err_flag,
    output logic [7:0]         err_count
);

    localparam int IW = $clog2(NREG);

    logic            write_s, in_range_s, fmt_err_s;
    logic [IW-1:0]   index_s;
    logic [AW-1:0]   srcaddr_s, dstaddr_s;
    logic [31:0]     wdata_s, rdata_s;
    logic [CM_W-1:0] ctrlmode_s;
    logic            accept_s, rd_acc_s, req_err_s, idx_zero_s, wr_en_s, err_acc_s;
    logic [PW-1:0]   rsp_pkt_s;

    logic [31:0]     reg_bank_r [NREG];
    rsp_state_e      state_r;
    logic            rsp_access_r;
    logic [PW-1:0]   rsp_packet_r;
    logic            err_flag_r;
    logic [7:0]      err_count_r;

    mcse_gpio_pkt_decode #(
        .AW        (AW),
        .PW        (PW),
        .NREG      (NREG),
        .IW        (IW),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .packet   (reg_packet),
        .write    (write_s),
        .index    (index_s),
        .in_range (in_range_s),
        .err      (fmt_err_s),
        .srcaddr  (srcaddr_s),
        .dstaddr  (dstaddr_s),
        .wdata    (wdata_s),
        .ctrlmode (ctrlmode_s)
    );

    assign reg_wait   = rsp_access_r && rsp_wait;
    assign rsp_access = rsp_access_r;
    assign rsp_packet = rsp_packet_r;
    assign err_flag   = err_flag_r;
    assign err_count  = err_count_r;

    // Accept qualification and error classification; index 0 is read-only.
    always_comb begin
        accept_s   = reg_access && !reg_wait;
        rd_acc_s   = accept_s && !write_s;
        req_err_s  = fmt_err_s || !in_range_s;
        idx_zero_s = (index_s == {IW{1'b0}});
        wr_en_s    = accept_s && write_s && !req_err_s && !idx_zero_s;
        err_acc_s  = accept_s && (req_err_s || (write_s && idx_zero_s));
    end

    // Read data as seen before any write landing on the same edge.
    always_comb begin
        if (req_err_s) begin
            rdata_s = ERR_RDATA;
        end else if (idx_zero_s) begin
            rdata_s = BLOCK_ID;
        end else begin
            rdata_s = reg_bank_r[index_s];
        end
    end

    // Response packet: addresses swapped so it routes back to the requester.
    always_comb begin
        rsp_pkt_s                         = {PW{1'b0}};
        rsp_pkt_s[WRITE_POS]              = 1'b1;
        rsp_pkt_s[DM_LSB +: DM_W]         = DM_WORD;
        rsp_pkt_s[CM_LSB +: CM_W]         = ctrlmode_s;
        rsp_pkt_s[DST_LSB +: AW]          = srcaddr_s;
        rsp_pkt_s[data_lsb(AW) +: DATA_W] = rdata_s;
        rsp_pkt_s[src_lsb(AW) +: AW]      = dstaddr_s;
    end

    // Register bank; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_bank_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en_s) begin
            reg_bank_r[index_s] <= wdata_s;
        end
    end

    // Response channel FSM; while the receiver waits the packet is held untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= RSP_IDLE;
            rsp_access_r <= 1'b0;
            rsp_packet_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                RSP_IDLE: begin
                    if (rd_acc_s) begin
                        state_r      <= RSP_BUSY;
                        rsp_access_r <= 1'b1;
                        rsp_packet_r <= rsp_pkt_s;
                    end
                end
                RSP_BUSY: begin
                    if (!rsp_wait) begin
                        if (rd_acc_s) begin
                            rsp_packet_r <= rsp_pkt_s;
                        end else begin
                            state_r      <= RSP_IDLE;
                            rsp_access_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r      <= RSP_IDLE;
                    rsp_access_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag and saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag_r  <= 1'b0;
            err_count_r <= 8'h00;
        end else if (err_acc_s) begin
            err_flag_r <= 1'b1;
            if (err_count_r != 8'hFF) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
        if (gi == 0) begin : g_id
            assign regs_out[31:0] = BLOCK_ID;
        end else begin : g_reg
            assign regs_out[32*gi +: 32] = reg_bank_r[gi];
        end
    end

endmodule

// File: tb/tb_mcse_gpio_reg_responder.sv
// Randomised self-checking bench for mcse_gpio_reg_responder against an
// address-rule reference model of the register window and error statistics.
module tb_mcse_gpio_reg_responder;

    localparam int          PW   = 104;
    localparam int          NREG = 8;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam logic [31:0] BID  = 32'h4D43_5345;

    logic              clk = 1'b0;
    logic              rst, reg_access, rsp_wait;
    logic [PW-1:0]     reg_packet;
    logic              reg_wait, rsp_access, err_flag;
    logic [PW-1:0]     rsp_packet;
    logic [NREG*32-1:0] regs_out;
    logic [7:0]        err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   m_regs [NREG];
    int            m_err;
    logic [PW-1:0] exp_pkt;
    logic          cur_w;
    logic [1:0]    cur_dm;
    logic [31:0]   cur_dst, cur_data;

    always #5 clk = ~clk;

    mcse_gpio_reg_responder dut (
        .clk        (clk),
        .rst        (rst),
        .reg_access (reg_access),
        .reg_packet (reg_packet),
        .reg_wait   (reg_wait),
        .rsp_access (rsp_access),
        .rsp_packet (rsp_packet),
        .rsp_wait   (rsp_wait),
        .regs_out   (regs_out),
        .err_flag   (err_flag),
        .err_count  (err_count)
    );

    function automatic logic m_bad(input logic [1:0] dm, input logic [31:0] dst);
        longint d;
        d = longint'(dst);
        return (d < longint'(BASE)) || (d >= longint'(BASE) + 4 * NREG) ||
               (dst[1:0] != 2'b00) || (dm != 2'b10);
    endfunction

    function automatic int m_idx(input logic [31:0] dst);
        return int'((dst - BASE) / 4);
    endfunction

    function automatic logic [NREG*32-1:0] m_flat();
        logic [NREG*32-1:0] f;
        f[31:0] = BID;
        for (int i = 1; i < NREG; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
        m_err = 0;
    endtask

    // Present a request and predict its response from the current model state.
    task automatic drive(input logic w, input logic [1:0] dm, input logic [4:0] ctrl,
                         input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
        logic [31:0] rd;
        if (m_bad(dm, dst)) rd = 32'hDEAD_BEEF;
        else if (m_idx(dst) == 0) rd = BID;
        else rd = m_regs[m_idx(dst)];
        reg_packet = {src, data, dst, ctrl, dm, w};
        exp_pkt    = {dst, rd, src, ctrl, 2'b10, 1'b1};
        cur_w = w; cur_dm = dm; cur_dst = dst; cur_data = data;
        reg_access = 1'b1;
    endtask

    // Apply the accepted request to the model.
    task automatic commit();
        if (m_bad(cur_dm, cur_dst) || (cur_w && m_idx(cur_dst) == 0)) begin
            if (m_err < 255) m_err++;
        end else if (cur_w) begin
            m_regs[m_idx(cur_dst)] = cur_data;
        end
    endtask

    task automatic send(input logic w, input logic [1:0] dm, input logic [4:0] ctrl,
                        input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
        @(negedge clk);
        drive(w, dm, ctrl, dst, data, src);
        @(posedge clk);
        commit();
        #1 reg_access = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (rsp_access !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_access: got %b want 0", rsp_access); end
        n_checks++; if (reg_wait !== 1'b0) begin n_fail++; $display("FAIL reset_reg_wait: got %b want 0", reg_wait); end
        n_checks++; if (err_flag !== 1'b0 || err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %b/%h want 0/00", err_flag, err_count); end
        n_checks++; if (rsp_packet !== {PW{1'b0}}) begin n_fail++; $display("FAIL reset_rsp_packet: got %h want 0", rsp_packet); end
        n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL reset_regs: got %h want %h", regs_out, m_flat()); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_write_read();
        send(1'b1, 2'b10, 5'd0, 32'h4004, 32'hA5A5_0001, 32'h0);
        n_checks++; if (rsp_access !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", rsp_access); end
        n_checks++; if (regs_out[63:32] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_reg1: got %h want a5a50001", regs_out[63:32]); end
        send(1'b0, 2'b10, 5'h13, 32'h4004, 32'h0, 32'h8000);
        n_checks++; if (rsp_access !== 1'b1) begin n_fail++; $display("FAIL rd_access: got %b want 1", rsp_access); end
        n_checks++; if (rsp_packet[40 +: 32] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_data: got %h want a5a50001", rsp_packet[40 +: 32]); end
        n_checks++; if (rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL rd_packet: got %h want %h", rsp_packet, exp_pkt); end
    endtask

    task automatic test_block_id();
        send(1'b0, 2'b10, 5'h01, 32'h4000, 32'h0, 32'h1111);
        n_checks++; if (rsp_packet[40 +: 32] !== 32'h4D43_5345) begin n_fail++; $display("FAIL id_data: got %h want 4d435345", rsp_packet[40 +: 32]); end
        n_checks++; if (rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL id_packet: got %h want %h", rsp_packet, exp_pkt); end
        send(1'b1, 2'b10, 5'h00, 32'h4000, 32'h1234, 32'h0);
        n_checks++; if (regs_out[31:0] !== BID) begin n_fail++; $display("FAIL id_ro: got %h want %h", regs_out[31:0], BID); end
        n_checks++; if (err_flag !== 1'b1 || err_count !== 8'd1) begin n_fail++; $display("FAIL id_err: got %b/%h want 1/01", err_flag, err_count); end
    endtask

    task automatic test_errors();
        send(1'b0, 2'b10, 5'h02, 32'h4020, 32'h0, 32'h2222);
        n_checks++; if (rsp_access !== 1'b1 || rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL err_oor: got %b/%h want 1/%h", rsp_access, rsp_packet, exp_pkt); end
        send(1'b0, 2'b10, 5'h03, 32'h4006, 32'h0, 32'h3333);
        n_checks++; if (rsp_packet[40 +: 32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_misal: got %h want deadbeef", rsp_packet[40 +: 32]); end
        n_checks++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL err_count3: got %h want 03", err_count); end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] pa;
        send(1'b1, 2'b10, 5'h0, 32'h4008, 32'h0000_2222, 32'h0);
        send(1'b1, 2'b10, 5'h0, 32'h400C, 32'h0000_3333, 32'h0);
        rsp_wait = 1'b1;
        send(1'b0, 2'b10, 5'h05, 32'h4008, 32'h0, 32'h0000_9000);
        pa = exp_pkt;
        @(negedge clk);
        drive(1'b0, 2'b10, 5'h06, 32'h400C, 32'h0, 32'h0000_9004);
        repeat (5) begin
            @(posedge clk); #1;
            n_checks++; if (rsp_packet !== pa || rsp_access !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/%h", rsp_access, rsp_packet, pa); end
            n_checks++; if (reg_wait !== 1'b1) begin n_fail++; $display("FAIL bp_reg_wait: got %b want 1", reg_wait); end
        end
        @(negedge clk) rsp_wait = 1'b0;
        @(posedge clk);
        commit();
        #1 reg_access = 1'b0;
        n_checks++; if (rsp_access !== 1'b1 || rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL bp_second: got %b/%h want 1/%h", rsp_access, rsp_packet, exp_pkt); end
        @(posedge clk); #1;
        n_checks++; if (rsp_access !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", rsp_access); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 2'b10, 5'($urandom), BASE + 32'(4 * $urandom_range(0, NREG-1)), $urandom, $urandom);
            @(posedge clk);
            commit();
            #1;
            n_checks++; if (rsp_access !== 1'b1 || rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", k, rsp_access, rsp_packet, exp_pkt); end
        end
        reg_access = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rsp_access !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", rsp_access); end
    endtask

    task automatic test_random();
        logic       w;
        logic [1:0] dm;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom);
            dm = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            send(w, dm, 5'($urandom), BASE - 32'd8 + 32'($urandom_range(0, 48)), $urandom, $urandom);
            if (!w) begin
                n_checks++; if (rsp_access !== 1'b1 || rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL rnd_rd_%0d: got %b/%h want 1/%h", n, rsp_access, rsp_packet, exp_pkt); end
            end else begin
                n_checks++; if (rsp_access !== 1'b0 || regs_out !== m_flat()) begin n_fail++; $display("FAIL rnd_wr_%0d: got %b/%h want 0/%h", n, rsp_access, regs_out, m_flat()); end
            end
            n_checks++; if (err_count !== 8'(m_err) || err_flag !== (m_err > 0)) begin n_fail++; $display("FAIL rnd_err_%0d: got %b/%h want %b/%h", n, err_flag, err_count, (m_err > 0), 8'(m_err)); end
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(1'b1, 2'b00, 5'h0, 32'h4008, $urandom, 32'h0);
            @(posedge clk);
            commit();
        end
        #1 reg_access = 1'b0;
        n_checks++; if (err_count !== 8'hFF || err_flag !== 1'b1) begin n_fail++; $display("FAIL sat_count: got %b/%h want 1/ff", err_flag, err_count); end
        n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL sat_regs: got %h want %h", regs_out, m_flat()); end
    endtask

    task automatic test_async_reset();
        rsp_wait = 1'b1;
        send(1'b0, 2'b10, 5'h07, 32'h4004, 32'h0, 32'h0000_7000);
        n_checks++; if (rsp_access !== 1'b1) begin n_fail++; $display("FAIL ar_pending: got %b want 1", rsp_access); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (rsp_access !== 1'b0 || reg_wait !== 1'b0) begin n_fail++; $display("FAIL ar_rsp: got %b/%b want 0/0", rsp_access, reg_wait); end
        n_checks++; if (regs_out[NREG*32-1:32] !== {(NREG-1)*32{1'b0}}) begin n_fail++; $display("FAIL ar_regs: got %h want 0", regs_out[NREG*32-1:32]); end
        n_checks++; if (err_count !== 8'h00 || err_flag !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b/%h want 0/00", err_flag, err_count); end
        n_checks++; if (rsp_packet !== {PW{1'b0}}) begin n_fail++; $display("FAIL ar_packet: got %h want 0", rsp_packet); end
        m_clear();
        @(negedge clk);
        rst = 1'b1;
        rsp_wait = 1'b0;
        send(1'b0, 2'b10, 5'h08, 32'h4004, 32'h0, 32'h0000_7004);
        n_checks++; if (rsp_packet !== exp_pkt) begin n_fail++; $display("FAIL ar_after: got %h want %h", rsp_packet, exp_pkt); end
    endtask

    initial begin
        rst = 1'b0;
        reg_access = 1'b0;
        reg_packet = {PW{1'b0}};
        rsp_wait = 1'b0;
        m_clear();
        test_reset();
        test_write_read();
        test_block_id();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
